// File: rtl/coin_acceptor_if.sv
// Coin/cancel front end for the vending FSM: synchronise, debounce, encode and
// hand over one confirm (or reject) per physical event, deferring while the FSM is busy.
module coin_acceptor_if #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned RELEASE_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin5_raw,
    input  logic       coin10_raw,
    input  logic       coin25_raw,
    input  logic       cancel_raw,
    input  logic       vend_busy,
    output logic [1:0] coin_code,
    output logic       confirm,
    output logic       reject,
    output logic       pending
);

    localparam int unsigned MAX_CYCLES = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ?
                                         DEBOUNCE_CYCLES : RELEASE_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DEB = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_REL = CNT_W'(RELEASE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PEND     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [1:0]       r_state;
    logic [3:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_coin_code;
    logic             r_confirm;
    logic             r_reject;
    logic             r_pending;

    logic [1:0]       w_state_nxt;
    logic [3:0]       w_cand_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [1:0]       w_code_nxt;
    logic             w_confirm_nxt;
    logic             w_reject_nxt;
    logic [3:0]       w_raw;

    assign w_raw     = {cancel_raw, coin25_raw, coin10_raw, coin5_raw};
    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_ONE;

    function automatic logic [1:0] enc(input logic [3:0] v);
        logic [1:0] code;
        code = 2'b00;
        case (v)
            4'b0001: code = 2'b01;
            4'b0010: code = 2'b10;
            4'b0100: code = 2'b11;
            default: code = 2'b00;
        endcase
        return code;
    endfunction

    // Two-flop synchroniser for all four raw lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State, candidate, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cand      <= 4'b0000;
            r_cnt       <= '0;
            r_coin_code <= 2'b00;
            r_confirm   <= 1'b0;
            r_reject    <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_coin_code <= w_code_nxt;
            r_confirm   <= w_confirm_nxt;
            r_reject    <= w_reject_nxt;
            r_pending   <= (w_state_nxt == ST_PEND);
        end
    end

    // Next-state logic; a qualified multi-hot candidate is rejected, never prioritised
    always_comb begin
        w_state_nxt   = r_state;
        w_cand_nxt    = r_cand;
        w_cnt_nxt     = r_cnt;
        w_code_nxt    = r_coin_code;
        w_confirm_nxt = 1'b0;
        w_reject_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync2 != 4'b0000) begin
                    w_cand_nxt = r_sync2;
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_cnt_nxt = '0;
                        if ($onehot(r_sync2)) begin
                            w_state_nxt = ST_PEND;
                        end else begin
                            w_reject_nxt = 1'b1;
                            w_state_nxt  = ST_RELEASE;
                        end
                    end else begin
                        w_cnt_nxt   = CNT_ONE;
                        w_state_nxt = ST_DEBOUNCE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (r_sync2 != r_cand) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_inc == CNT_DEB) begin
                    w_cnt_nxt = '0;
                    if ($onehot(r_cand)) begin
                        w_state_nxt = ST_PEND;
                    end else begin
                        w_reject_nxt = 1'b1;
                        w_state_nxt  = ST_RELEASE;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_PEND: begin
                if (!vend_busy) begin
                    w_code_nxt    = enc(r_cand);
                    w_confirm_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_RELEASE;
                end
            end
            default: begin
                if (r_sync2 != 4'b0000) begin
                    w_cnt_nxt = '0;
                end else if (w_cnt_inc == CNT_REL) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
        endcase
    end

    assign coin_code = r_coin_code;
    assign confirm   = r_confirm;
    assign reject    = r_reject;
    assign pending   = r_pending;

endmodule

// File: tb/tb_coin_acceptor_if.sv
// Randomised bench for coin_acceptor_if: a sample-stream reference model pushes
// expected strobes into a queue; an independent monitor pops and compares them.
module tb_coin_acceptor_if;

    localparam int unsigned DEB = 4;
    localparam int unsigned REL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin5_raw = 1'b0, coin10_raw = 1'b0, coin25_raw = 1'b0, cancel_raw = 1'b0;
    logic       vend_busy = 1'b0;
    logic [1:0] coin_code;
    logic       confirm, reject, pending;

    coin_acceptor_if #(.DEBOUNCE_CYCLES(DEB), .RELEASE_CYCLES(REL)) dut (
        .clk(clk), .rst_n(rst_n),
        .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
        .coin25_raw(coin25_raw), .cancel_raw(cancel_raw),
        .vend_busy(vend_busy),
        .coin_code(coin_code), .confirm(confirm), .reject(reject), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_rej;
        logic [1:0] code;
        int         cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic [1:0] exp_code    = 2'b00;
    logic       exp_pending = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Coin line index -> FSM code; the cancel line maps to 00
    function automatic logic [1:0] code_of(input logic [3:0] v);
        for (int i = 0; i < 3; i++)
            if (v == (4'b0001 << i)) return 2'(i + 1);
        return 2'b00;
    endfunction

    // Reference model over the twice-delayed sample stream
    initial begin : model
        logic [3:0] p1, p2, v, cand;
        int run, zeros;
        bit armed, waiting;
        p1 = 0; p2 = 0; cand = 0; run = 0; zeros = 0; armed = 1; waiting = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                p1 = 0; p2 = 0; cand = 0; run = 0; zeros = 0; armed = 1; waiting = 0;
                exp_code = 2'b00;
            end else begin
                v  = p2;
                p2 = p1;
                p1 = {cancel_raw, coin25_raw, coin10_raw, coin5_raw};
                if (waiting) begin
                    if (!vend_busy) begin
                        exp_code = code_of(cand);
                        exp_q.push_back('{is_rej: 0, code: exp_code, cyc: cyc});
                        waiting = 0; zeros = 0;
                    end
                end else if (armed) begin
                    if (run > 0 && v != cand) run = 0;
                    else if (v != 0) begin
                        if (run == 0) cand = v;
                        run++;
                    end
                    if (run == int'(DEB)) begin
                        run = 0; armed = 0;
                        if ($countones(cand) == 1) waiting = 1;
                        else begin
                            exp_q.push_back('{is_rej: 1, code: exp_code, cyc: cyc});
                            zeros = 0;
                        end
                    end
                end else begin
                    zeros = (v == 0) ? zeros + 1 : 0;
                    if (zeros == int'(REL)) begin armed = 1; zeros = 0; end
                end
            end
            exp_pending = waiting;
        end
    end

    // Monitor: pops the scoreboard whenever a strobe appears
    initial begin : monitor
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (confirm || reject) begin
                if (exp_q.size() == 0) begin
                    chk(confirm ? "unexpected_confirm" : "unexpected_reject", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind_reject", int'(reject), int'(e.is_rej));
                    chk("strobe_kind_confirm", int'(confirm), int'(!e.is_rej));
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("coin_code_at_strobe", int'(coin_code), int'(e.code));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk("missing_strobe_at_cycle", cyc, e.cyc);
            end
            chk("pending", int'(pending), int'(exp_pending));
            chk("coin_code_hold", int'(coin_code), int'(exp_code));
        end
    end

    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        {cancel_raw, coin25_raw, coin10_raw, coin5_raw} = v;
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        drive(v);
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin : stim
        int kind, len;
        logic [3:0] v;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_confirm", int'(confirm), 0);
        chk("reset_reject", int'(reject), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_code", int'(coin_code), 0);
        rst_n = 1'b1;
        hold(4'b0000, 4);
        // Directed scenarios: held coin, short pulse, multi-hot, deferred, bounce-back cancel
        hold(4'b0010, 20); hold(4'b0000, 10);
        hold(4'b0100, 2);  hold(4'b0000, 10);
        hold(4'b1001, 10); hold(4'b0000, 10);
        vend_busy = 1'b1;
        hold(4'b0001, 10); hold(4'b0000, 20);
        vend_busy = 1'b0;
        hold(4'b0000, 10);
        hold(4'b1000, 8); hold(4'b0000, 2); hold(4'b1000, 8); hold(4'b0000, 12);
        // Reset while an event is pending
        vend_busy = 1'b1;
        hold(4'b0100, 10); hold(4'b0000, 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_pend_confirm", int'(confirm), 0);
        chk("rst_pend_pending", int'(pending), 0);
        chk("rst_pend_code", int'(coin_code), 0);
        @(negedge clk);
        rst_n = 1'b1;
        vend_busy = 1'b0;
        hold(4'b0000, 15);
        // Randomised segments
        for (int s = 0; s < 250; s++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6)      v = 4'b0001 << $urandom_range(0, 3);
            else if (kind < 8) v = 4'($urandom_range(1, 15));
            else               v = 4'b0000;
            len = $urandom_range(1, 14);
            if ($urandom_range(0, 4) == 0) vend_busy = ~vend_busy;
            hold(v, len);
            if ($urandom_range(0, 2) != 0) hold(4'b0000, $urandom_range(1, 9));
        end
        vend_busy = 1'b0;
        hold(4'b0000, 30);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
